// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the data-memory strobe/ready handshake.
// A single-cycle requester transaction (req/we/addr/wdata) is latched and
// turned into a held memory access (memCs + memRead/memWrite). The access is
// closed when the synchronised ready (rdy_smp) is seen, a one-cycle ack is
// returned, and the controller waits for ready to drop before the next request.
//
// Handshake: a request is taken on a rising clk edge where req=1 and busy=0.
// req while busy=1 is dropped, not queued. ack pulses for exactly one cycle per
// completed access, and rdata is valid from that ack onward.
//
// Optional build macro MEM_TIMEOUT_EN: adds an ACCESS-state cycle counter.
// The access is abandoned after TIMEOUT_CYCLES cycles without ready, and ack
// is returned together with err. Without the macro, ACCESS waits
// indefinitely and err is tied low.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int dataWidth      = 8,
  parameter int addrWidth      = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [addrWidth-1:0] addr,
  input  logic [dataWidth-1:0] wdata,
  output logic                 busy,
  output logic                 ack,
  output logic [dataWidth-1:0] rdata,
  output logic                 err,
  output logic                 memCs,
  output logic                 memRead,
  output logic                 memWrite,
  output logic [addrWidth-1:0] memAddress,
  output logic [dataWidth-1:0] memDataOut,
  input  logic [dataWidth-1:0] memDataIn,
  input  logic                 memDataReady,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RELEASE  = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   rdy_smp;
  logic                   we_lat;
  logic [addrWidth-1:0]   addr_lat;
  logic [dataWidth-1:0]   wdata_lat;
  logic                   accept;
  logic                   timeout;

  assign busy      = (state != IDLE) | rdy_smp;
  assign accept    = (state == IDLE) & req & ~busy;
  assign fsm_state = state;

  // The memory sees only the latched copies, so address and data cannot move
  // while the strobes are up (a change would retrigger the memory).
  assign memAddress = addr_lat;
  assign memDataOut = wdata_lat;

  // Single-flop sample of the asynchronous ready pulse; the FSM looks only at this.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_smp <= 1'b0;
    else     rdy_smp <= memDataReady;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          err_lat;

  // Fires on the last allowed ACCESS cycle if ready has still not been seen.
  assign timeout = (state == ACCESS) & ~rdy_smp & (cnt == CNT_LAST);
  assign err     = (state == RELEASE) & err_lat;

  // ACCESS cycle counter, plus a flag remembering why ACCESS was left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      err_lat <= 1'b0;
    end else begin
      if (accept)                cnt <= '0;
      else if (state == ACCESS)  cnt <= cnt + 1'b1;
      if (state == ACCESS)       err_lat <= timeout;
    end
  end
`else
  // No counter in this build: the comparison is never true, so ACCESS waits
  // for ready indefinitely.
  assign timeout = (TIMEOUT_CYCLES < 0);
  assign err     = 1'b0;
`endif

  // State register; reset is asynchronous so the strobes drop with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and strobe/ack decode.
  always_comb begin
    state_next = state;
    memCs      = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    ack        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = ACCESS;
      end
      ACCESS: begin
        memCs    = 1'b1;
        memRead  = ~we_lat;
        memWrite = we_lat;
        if (rdy_smp || timeout) state_next = RELEASE;
      end
      RELEASE: begin
        ack        = 1'b1;
        state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        // The memory may keep ready high after cs falls; wait it out.
        if (!rdy_smp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch and read-data capture. memDataIn is sampled only while the
  // read strobe is still high, so a floating bus is never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_lat    <= 1'b0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        we_lat    <= we;
        addr_lat  <= addr;
        wdata_lat <= wdata;
      end
      if ((state == ACCESS) && rdy_smp && !we_lat) rdata <= memDataIn;
    end
  end

endmodule
